// File: rtl/mac_seq_pkg.sv
// Shared constants for the mac dot-product sequencer: widths, FSM encodings
// and the operand drive used whenever no pair is being transferred.
package mac_seq_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int LEN_W_DEF  = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Hold drive: zero operands with accumulate set leaves mac_out unchanged.
  localparam logic MAC_HOLD_ACC = 1'b1;

endpackage

// File: rtl/mac_seq_ctrl.sv
// Sequencer for one mac dot-product job: start/len in, N operand pairs in,
// captured sum out. Optional abort input enabled by MAC_SEQ_ABORT_EN.
//
// Handshakes: a transfer happens on any rising edge where valid & ready are
// both high. in_ready never depends on in_valid; result_valid stays high and
// result stays stable until result_ready is seen.
module mac_seq_ctrl
  import mac_seq_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
`ifdef MAC_SEQ_ABORT_EN
  input  logic              abort,
`endif
  input  logic              start,
  input  logic [LEN_W-1:0]  vec_len,
  output logic              busy,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  output logic [DATA_W-1:0] mac_a,
  output logic [DATA_W-1:0] mac_b,
  output logic              mac_acc,
  input  logic [DATA_W-1:0] mac_out,
  output logic [DATA_W-1:0] result,
  output logic              result_valid,
  input  logic              result_ready,
  output logic [1:0]        state_dbg
);

  logic [1:0]        state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              result_valid_q, result_valid_d;
  logic              abort_hit;
  logic              xfer;

`ifdef MAC_SEQ_ABORT_EN
  assign abort_hit = abort && ((state_q == ST_RUN) || (state_q == ST_DRAIN));
`else
  assign abort_hit = 1'b0;
`endif

  assign in_ready = (state_q == ST_RUN) && !abort_hit;
  assign xfer     = in_valid && in_ready;

  // First pair loads the raw product, later pairs accumulate.
  always_comb begin
    mac_a   = '0;
    mac_b   = '0;
    mac_acc = MAC_HOLD_ACC;
    if (xfer) begin
      mac_a   = in_a;
      mac_b   = in_b;
      mac_acc = (cnt_q != '0);
    end
  end

  always_comb begin
    state_d        = state_q;
    len_d          = len_q;
    cnt_d          = cnt_q;
    result_d       = result_q;
    result_valid_d = result_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (vec_len != '0) begin
            len_d   = vec_len;
            cnt_d   = '0;
            state_d = ST_RUN;
          end else begin
            result_d       = '0;
            result_valid_d = 1'b1;
            state_d        = ST_DONE;
          end
        end
      end
      ST_RUN: begin
        if (xfer) begin
          cnt_d = cnt_q + LEN_W'(1);
          if (cnt_q == len_q - LEN_W'(1)) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // The last product landed in mac_out on the previous edge.
        result_d       = mac_out;
        result_valid_d = 1'b1;
        state_d        = ST_DONE;
      end
      ST_DONE: begin
        if (result_ready) begin
          result_valid_d = 1'b0;
          state_d        = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (abort_hit) begin
      state_d        = ST_IDLE;
      cnt_d          = '0;
      result_d       = result_q;
      result_valid_d = result_valid_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_IDLE;
      len_q          <= '0;
      cnt_q          <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      len_q          <= len_d;
      cnt_q          <= cnt_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
    end
  end

  assign busy         = (state_q != ST_IDLE);
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Directed bench for mac_seq_ctrl with a small behavioural mac closing the loop.
module tb_mac_seq_ctrl;
  import mac_seq_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic [7:0] vec_len;
  logic       busy;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a, in_b;
  logic [7:0] mac_a, mac_b;
  logic       mac_acc;
  logic [7:0] mac_out;
  logic [7:0] result;
  logic       result_valid;
  logic       result_ready;
  logic [1:0] state_dbg;
`ifdef MAC_SEQ_ABORT_EN
  logic       abort;
`endif

  int total = 0;
  int bad   = 0;
  logic [7:0] va [4];
  logic [7:0] vb [4];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  mac_seq_ctrl dut (
    .clk          (clk),
    .reset_n      (reset_n),
`ifdef MAC_SEQ_ABORT_EN
    .abort        (abort),
`endif
    .start        (start),
    .vec_len      (vec_len),
    .busy         (busy),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_a         (in_a),
    .in_b         (in_b),
    .mac_a        (mac_a),
    .mac_b        (mac_b),
    .mac_acc      (mac_acc),
    .mac_out      (mac_out),
    .result       (result),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .state_dbg    (state_dbg)
  );

  // Behavioural mac: load product when acc=0, add product when acc=1, mod 256.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) mac_out <= 8'd0;
    else if (mac_acc) mac_out <= mac_out + mac_a * mac_b;
    else mac_out <= mac_a * mac_b;
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_job(input string tag, input int n, input int gap, input logic [7:0] exp_res);
    int cyc;
    logic [7:0] held;
    start   = 1'b1;
    vec_len = 8'(n);
    @(negedge clk);
    start   = 1'b0;
    vec_len = 8'hA5;
    cyc     = 1;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_a     = va[i];
      in_b     = vb[i];
      #1;
      check({tag, "_rdy"}, in_ready, 1);
      check({tag, "_acc"}, mac_acc, (i != 0));
      check({tag, "_maca"}, mac_a, va[i]);
      @(negedge clk);
      cyc++;
      if (i != n - 1) begin
        for (int g = 0; g < gap; g++) begin
          in_valid = 1'b0;
          in_a     = 8'($urandom_range(1, 255));
          in_b     = 8'($urandom_range(1, 255));
          held     = mac_out;
          @(negedge clk);
          cyc++;
          check({tag, "_stall_hold"}, mac_out, held);
        end
      end
    end
    in_valid = 1'b0;
    while (!result_valid && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_latency"}, cyc, n + gap * (n - 1) + 2);
    check({tag, "_result"}, result, exp_res);
    check({tag, "_busy"}, busy, 1);
  endtask

  task automatic finish_job(input string tag);
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
    check({tag, "_rv_clr"}, result_valid, 0);
    check({tag, "_idle"}, busy, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset_n = 1'b0; start = 1'b0; vec_len = 8'd0; in_valid = 1'b0;
    in_a = 8'd0; in_b = 8'd0; result_ready = 1'b0;
`ifdef MAC_SEQ_ABORT_EN
    abort = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_rdy", in_ready, 0);
    check("rst_rv", result_valid, 0);
    check("rst_res", result, 0);
    check("rst_acc", mac_acc, 1);
    check("rst_state", state_dbg, ST_IDLE);
    reset_n = 1'b1;
    @(negedge clk);

    // len=3, no stalls: 6+20+6 = 32
    va = '{8'd2, 8'd4, 8'd1, 8'd0}; vb = '{8'd3, 8'd5, 8'd6, 8'd0};
    do_job("t1", 3, 0, 8'd32);
    finish_job("t1");

    // len=2 wrap: 256+5 mod 256 = 5
    va = '{8'd16, 8'd1, 8'd0, 8'd0}; vb = '{8'd16, 8'd5, 8'd0, 8'd0};
    do_job("t2", 2, 0, 8'd5);
    finish_job("t2");

    // len=3 with 2 stall cycles between pairs: 9+4+1 = 14
    va = '{8'd3, 8'd2, 8'd1, 8'd0}; vb = '{8'd3, 8'd2, 8'd1, 8'd0};
    do_job("t3", 3, 2, 8'd14);
    finish_job("t3");

    // zero-length job
    start = 1'b1; vec_len = 8'd0;
    #1 check("t4_rdy_idle", in_ready, 0);
    @(negedge clk);
    start = 1'b0;
    check("t4_state", state_dbg, ST_DONE);
    check("t4_rdy", in_ready, 0);
    check("t4_rv", result_valid, 1);
    check("t4_res", result, 0);
    finish_job("t4");

    // result held under backpressure, start ignored in DONE: 12+30 = 42
    va = '{8'd3, 8'd5, 8'd0, 8'd0}; vb = '{8'd4, 8'd6, 8'd0, 8'd0};
    do_job("t5", 2, 0, 8'd42);
    for (int k = 0; k < 5; k++) begin
      start   = (k == 2);
      vec_len = 8'd1;
      @(negedge clk);
      check("t5_hold_res", result, 42);
      check("t5_hold_rv", result_valid, 1);
      check("t5_hold_state", state_dbg, ST_DONE);
    end
    start = 1'b0;
    finish_job("t5");
    va = '{8'd5, 8'd0, 8'd0, 8'd0}; vb = '{8'd5, 8'd0, 8'd0, 8'd0};
    do_job("t5b", 1, 0, 8'd25);
    finish_job("t5b");

    // async reset after 2nd of 4 transfers
    start = 1'b1; vec_len = 8'd4;
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b1; in_a = 8'd1; in_b = 8'd1;
    @(negedge clk);
    in_a = 8'd2; in_b = 8'd2;
    @(negedge clk);
    in_a = 8'd3; in_b = 8'd3;
    reset_n = 1'b0;
    #1;
    check("t6_busy", busy, 0);
    check("t6_rdy", in_ready, 0);
    check("t6_res", result, 0);
    check("t6_rv", result_valid, 0);
    check("t6_acc", mac_acc, 1);
    check("t6_maca", mac_a, 0);
    check("t6_macb", mac_b, 0);
    check("t6_state", state_dbg, ST_IDLE);
    @(negedge clk);
    reset_n = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    va = '{8'd7, 8'd0, 8'd0, 8'd0}; vb = '{8'd7, 8'd0, 8'd0, 8'd0};
    do_job("t6b", 1, 0, 8'd49);
    finish_job("t6b");

`ifdef MAC_SEQ_ABORT_EN
    // abort mid-run
    start = 1'b1; vec_len = 8'd3;
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b1; in_a = 8'd1; in_b = 8'd1;
    @(negedge clk);
    in_a = 8'd2; in_b = 8'd2; abort = 1'b1;
    #1 check("ab_rdy", in_ready, 0);
    @(negedge clk);
    abort = 1'b0; in_valid = 1'b0;
    check("ab_state", state_dbg, ST_IDLE);
    check("ab_rv", result_valid, 0);
    check("ab_res", result, 49);
    // abort coinciding with the final transfer
    start = 1'b1; vec_len = 8'd1;
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b1; in_a = 8'd9; in_b = 8'd9; abort = 1'b1;
    @(negedge clk);
    abort = 1'b0; in_valid = 1'b0;
    check("ab2_state", state_dbg, ST_IDLE);
    @(negedge clk);
    check("ab2_rv", result_valid, 0);
    check("ab2_res", result, 49);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mac_seq_ctrl.md
Name: mac_seq_ctrl

Overview:
Sequencer that drives the 8-bit mac datapath through one dot-product job: accept start with a vector length, stream N operand pairs in over a valid/ready handshake, and steer the MAC's accumulate control. Captures the final mac_out and presents it on a result valid/ready handshake. Sits between the operand source (buffer/DMA) and a mac instance; the pair is wrapped by the top level.

Parameters:
DATA_W, 8, operand and result width (matches mac in_a/in_b/mac_out)
LEN_W, 8, width of vector-length field; max job length 2^LEN_W-1

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
start  in  1  job request, sampled in IDLE only
vec_len  in  LEN_W  element count, latched with start
busy  out  1  high in any state except IDLE
in_valid  in  1  operand pair valid
in_ready  out  1  controller accepts operand pair
in_a  in  DATA_W  operand A
in_b  in  DATA_W  operand B
mac_a  out  DATA_W  to mac in_a
mac_b  out  DATA_W  to mac in_b
mac_acc  out  1  to mac accumulate
mac_out  in  DATA_W  from mac mac_out
result  out  DATA_W  captured dot product
result_valid  out  1  result available
result_ready  in  1  consumer takes result

Behaviour:
- Reset (async, reset_n=0): state IDLE; busy=0, in_ready=0, result=0, result_valid=0, element counter=0, mac_a=0, mac_b=0, mac_acc=1.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: start=1 and vec_len!=0 -> latch vec_len, clear counter, go RUN next cycle. start=1 and vec_len==0 -> go DONE with result=0. start=0 -> stay.
- RUN: in_ready=1. Transfer = in_valid & in_ready. On transfer, mac_a=in_a and mac_b=in_b combinationally. mac_acc=0 for the first element (mac loads the raw product), 1 thereafter. Counter increments per transfer. The transfer of element vec_len-1 goes to DRAIN.
- Non-transfer cycles (RUN stall, IDLE, DRAIN, DONE): mac_a=0, mac_b=0, mac_acc=1. mac_out is held because the MAC adds 0.
- DRAIN: one cycle. mac_out now holds the final sum. Register result<=mac_out, result_valid<=1 for the next cycle, go DONE.
- DONE: result_valid=1, result stable. result_ready=1 -> result_valid=0 next cycle, go IDLE. start is ignored while in DONE.
- start in RUN/DRAIN/DONE: ignored. vec_len changes after latch: no effect.
- Arithmetic: modulo 2^DATA_W, inherited from mac truncation. No saturation or overflow flag.
- Latency, start to result_valid: 1 + N transfer cycles + stall cycles + 1 (DRAIN). Minimum N+2 cycles.
- Back-to-back: a new start is accepted on the cycle after the DONE->IDLE transition.
- Reset mid-job: immediate return to IDLE reset values; no partial result is reported.

Optional Feature:
MAC_SEQ_ABORT_EN. When defined, adds input abort (1 bit).
- abort=1 in RUN or DRAIN: go IDLE next cycle, in_ready deasserts that cycle, result_valid is never raised, result is unchanged.
- abort in IDLE or DONE: ignored.
- abort in the same cycle as the final transfer: abort wins.
When undefined, there is no port and no logic.

Decomposition:
- Package mac_seq_pkg: state enum (IDLE, RUN, DRAIN, DONE), DATA_W/LEN_W defaults, constant for the hold-drive values (0, 0, acc=1).
- Single flat module; no sub-module needed. The top level mac_seq_top instantiates mac_seq_ctrl plus mac and inverts reset_n to the mac's active-high reset.

Test Plan:
- len=3, pairs (2,3),(4,5),(1,6) with no stalls -> result=32, result_valid asserted 5 cycles after the start cycle.
- len=2, pairs (16,16),(1,5) -> result=5 (261 mod 256); first transfer sees mac_acc=0, second sees mac_acc=1.
- len=3, pairs (3,3),(2,2),(1,1) with in_valid low 2 cycles between each pair -> result=14; mac_out unchanged across stall cycles.
- start with vec_len=0 -> DONE next cycle, result=0, no in_ready pulse.
- Hold result_ready=0 for 5 cycles after result_valid and pulse start -> result stable, start ignored, busy=1; raise result_ready -> IDLE, new job accepted.
- reset_n low after the 2nd of 4 transfers -> all outputs at reset values asynchronously; a fresh len=1 job (7,7) then yields 49.
